// File: rtl/serial_parity_pkg.sv
// Shared types and mode constants for the serial parity generator/checker.
package serial_parity_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PBIT = 2'd2,
        EMIT = 2'd3
    } state_t;

    localparam logic MODE_EVEN = 1'b0;
    localparam logic MODE_ODD  = 1'b1;
    localparam logic MODE_GEN  = 1'b0;
    localparam logic MODE_CHK  = 1'b1;

endpackage

// File: rtl/parity_acc.sv
// XOR accumulator: load restarts the word with one bit, acc_en folds in another.
// Registered value plus a look-ahead of the value it takes at the next edge.
module parity_acc (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic acc_en_i,
    input  logic bit_i,
    output logic acc_o,
    output logic acc_nxt_o
);

    logic acc_q;

    always_comb begin
        acc_nxt_o = acc_q;
        if (load_i) begin
            acc_nxt_o = bit_i;
        end else if (acc_en_i) begin
            acc_nxt_o = acc_q ^ bit_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= 1'b0;
        end else begin
            acc_q <= acc_nxt_o;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/serial_parity_unit.sv
// Serial parity generator/checker over WORD_BITS-bit words; result pulses one cycle
// after the last accepted bit, and in_ready drops only during that result cycle.
module serial_parity_unit
    import serial_parity_pkg::*;
#(
    parameter int WORD_BITS = 3,
    parameter int CNT_W     = $clog2(WORD_BITS + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic in_bit,
    output logic in_ready,
    input  logic odd_mode,
    input  logic check_mode,
    output logic out_valid,
    output logic out_bit,
    output logic par_err,
    output logic busy
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               odd_q, odd_d;
    logic               chk_q, chk_d;
    logic               out_bit_q, out_bit_d;
    logic               par_err_q, par_err_d;
    logic               acc_load, acc_en, acc, acc_nxt;
    logic               accept;

    assign accept = in_valid && in_ready;

    parity_acc u_acc (
        .clk       (clk),
        .reset     (reset),
        .load_i    (acc_load),
        .acc_en_i  (acc_en),
        .bit_i     (in_bit),
        .acc_o     (acc),
        .acc_nxt_o (acc_nxt)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        odd_d     = odd_q;
        chk_d     = chk_q;
        out_bit_d = out_bit_q;
        par_err_d = par_err_q;
        acc_load  = 1'b0;
        acc_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_load = 1'b1;
                    odd_d    = odd_mode;
                    chk_d    = check_mode;
                    cnt_d    = CNT_W'(1);
                    if (WORD_BITS == 1) begin
                        if (check_mode == MODE_CHK) begin
                            state_d = PBIT;
                        end else begin
                            state_d   = EMIT;
                            out_bit_d = acc_nxt ^ (odd_mode == MODE_ODD);
                            par_err_d = 1'b0;
                        end
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    acc_en = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WORD_BITS - 1)) begin
                        if (chk_q == MODE_CHK) begin
                            state_d = PBIT;
                        end else begin
                            state_d   = EMIT;
                            out_bit_d = acc_nxt ^ (odd_q == MODE_ODD);
                            par_err_d = 1'b0;
                        end
                    end
                end
            end
            PBIT: begin
                // The received parity bit is consumed straight into the error flag.
                if (accept) begin
                    state_d   = EMIT;
                    out_bit_d = acc ^ (odd_q == MODE_ODD);
                    par_err_d = acc ^ in_bit ^ (odd_q == MODE_ODD);
                end
            end
            EMIT: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            odd_q     <= MODE_EVEN;
            chk_q     <= MODE_GEN;
            out_bit_q <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            odd_q     <= odd_d;
            chk_q     <= chk_d;
            out_bit_q <= out_bit_d;
            par_err_q <= par_err_d;
        end
    end

    assign in_ready  = (state_q != EMIT);
    assign out_valid = (state_q == EMIT);
    assign busy      = (state_q != IDLE);
    assign out_bit   = out_bit_q;
    assign par_err   = par_err_q;

endmodule

// File: tb/tb_serial_parity_unit.sv
// Bench for serial_parity_unit: directed vector table, corner sequences, random run vs model.
module tb_serial_parity_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic in_valid, in_bit, odd_mode, check_mode;
    logic in_ready, out_valid, out_bit, par_err, busy;
    logic v1_in_valid, v1_in_bit, v1_odd_mode, v1_check_mode;
    logic v1_in_ready, v1_out_valid, v1_out_bit, v1_par_err, v1_busy;

    serial_parity_unit #(.WORD_BITS(3)) u0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
        .odd_mode(odd_mode), .check_mode(check_mode), .out_valid(out_valid),
        .out_bit(out_bit), .par_err(par_err), .busy(busy)
    );

    serial_parity_unit #(.WORD_BITS(1)) u1 (
        .clk(clk), .reset(reset), .in_valid(v1_in_valid), .in_bit(v1_in_bit), .in_ready(v1_in_ready),
        .odd_mode(v1_odd_mode), .check_mode(v1_check_mode), .out_valid(v1_out_valid),
        .out_bit(v1_out_bit), .par_err(v1_par_err), .busy(v1_busy)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       chk;
        logic       odd;
        logic [2:0] data;   // sent MSB first
        logic       rx;
        logic       exp_bit;
        logic       exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one bit on u0 and hold it until accepted; returns at the following negedge.
    task automatic put(input logic b);
        int g;
        g = 0;
        in_valid = 1'b1;
        in_bit   = b;
        while (!in_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("put_ready", 8'(in_ready), 8'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_word(input vec_t v, input string nm);
        odd_mode   = v.odd;
        check_mode = v.chk;
        for (int i = 2; i >= 0; i--) put(v.data[i]);
        if (v.chk) put(v.rx);
        check(nm, 8'({out_valid, out_bit, par_err}), 8'({1'b1, v.exp_bit, v.exp_err}));
        @(negedge clk);
        check({nm, "_after"}, 8'({out_valid, busy, in_ready}), 8'b001);
    endtask

    // Random-phase reference model state
    localparam int W = 3;
    int   m_n;
    logic m_chk, m_odd, m_dpar, m_rx, m_emit, m_out, m_err;

    initial begin
        int   idx, nres, rdy0, cyc;
        int   t[3];
        logic ob[3];
        logic [5:0] bits6;
        logic [2:0] bits3;

        reset = 1'b1;
        in_valid = 0; in_bit = 0; odd_mode = 0; check_mode = 0;
        v1_in_valid = 0; v1_in_bit = 0; v1_odd_mode = 0; v1_check_mode = 0;

        //            chk odd data    rx exp_bit exp_err
        vecs[0] = '{1'b0, 1'b1, 3'b101, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 3'b111, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 3'b100, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 3'b001, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        check("rst_u0", 8'({out_valid, out_bit, par_err, busy}), 8'd0);
        check("rst_u1", 8'({v1_out_valid, v1_out_bit, v1_par_err, v1_busy}), 8'd0);
        reset = 1'b0;
        #1;
        check("rdy_after_rst", 8'({in_ready, v1_in_ready}), 8'b11);

        for (int i = 0; i < 8; i++) run_word(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back words with in_valid held high through EMIT
        bits6 = 6'b111_011;
        idx = 0; nres = 0; rdy0 = 0; cyc = 0;
        odd_mode = 0; check_mode = 0;
        while (nres < 2 && cyc < 40) begin
            if (out_valid) begin t[nres] = cyc; ob[nres] = out_bit; nres++; end
            if (!in_ready) rdy0++;
            if (idx < 6) begin
                in_valid = 1'b1;
                in_bit   = bits6[5 - idx];
                if (in_ready) idx++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("b2b_count", 8'(nres), 8'd2);
        check("b2b_spacing", 8'(t[1] - t[0]), 8'd4);
        check("b2b_bits", 8'({ob[0], ob[1]}), 8'b10);
        check("b2b_rdy_low", 8'(rdy0), 8'd2);

        // Stall of 5 idle cycles mid-word
        odd_mode = 1; check_mode = 0;
        put(1'b1);
        repeat (5) @(negedge clk);
        check("stall_busy", 8'({busy, out_valid}), 8'b10);
        put(1'b0);
        put(1'b1);
        check("stall_result", 8'({out_valid, out_bit, par_err}), 8'b110);
        @(negedge clk);

        // Mid-word reset after a result with both outputs set
        run_word('{1'b1, 1'b0, 3'b001, 1'b0, 1'b1, 1'b1}, "pre_reset");
        odd_mode = 0; check_mode = 0;
        put(1'b1);
        put(1'b1);
        check("mid_busy", 8'(busy), 8'd1);
        reset = 1'b1;
        #1;
        check("async_rst", 8'({out_valid, out_bit, par_err, busy}), 8'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("no_emit_after_rst", 8'({out_valid, busy}), 8'd0);
        end
        run_word('{1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0}, "post_reset");

        // Mode changes after the first bit must not affect the word
        odd_mode = 1; check_mode = 0;
        put(1'b1);
        odd_mode = 0; check_mode = 1;
        put(1'b0);
        put(1'b0);
        check("mode_locked", 8'({out_valid, out_bit, par_err}), 8'b100);
        @(negedge clk);
        check_mode = 0;

        // WORD_BITS=1 instance: odd parity, stream 1,0,1
        bits3 = 3'b101;
        idx = 0; nres = 0; cyc = 0;
        v1_odd_mode = 1; v1_check_mode = 0;
        while (nres < 3 && cyc < 40) begin
            if (v1_out_valid) begin t[nres] = cyc; ob[nres] = v1_out_bit; nres++; end
            if (idx < 3) begin
                v1_in_valid = 1'b1;
                v1_in_bit   = bits3[2 - idx];
                if (v1_in_ready) idx++;
            end else begin
                v1_in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        v1_in_valid = 1'b0;
        check("w1_count", 8'(nres), 8'd3);
        check("w1_bits", 8'({ob[0], ob[1], ob[2]}), 8'b010);
        check("w1_spacing", 8'({4'(t[1] - t[0]), 4'(t[2] - t[1])}), 8'h22);

        // Random traffic against the reference model
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_n = 0; m_emit = 0; m_out = 0; m_err = 0;
        m_chk = 0; m_odd = 0; m_dpar = 0; m_rx = 0;
        for (int c = 0; c < 3000; c++) begin
            check("rand", 8'({in_ready, out_valid, busy, out_bit, par_err}),
                  8'({!m_emit, m_emit, (m_emit || m_n > 0), m_out, m_err}));
            in_valid   = ($urandom_range(0, 3) != 0);
            in_bit     = 1'($urandom);
            odd_mode   = 1'($urandom);
            check_mode = 1'($urandom);
            if (m_emit) begin
                m_emit = 0;
            end else if (in_valid) begin
                if (m_n == 0) begin
                    m_chk = check_mode; m_odd = odd_mode; m_dpar = 0;
                end
                if (m_n < W) m_dpar = m_dpar ^ in_bit;
                else         m_rx   = in_bit;
                m_n++;
                if (m_n == W + (m_chk ? 1 : 0)) begin
                    m_emit = 1;
                    m_out  = m_dpar ^ m_odd;
                    m_err  = m_chk ? (m_dpar ^ m_rx ^ m_odd) : 1'b0;
                    m_n    = 0;
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_parity_unit.md
# serial_parity_unit

Parametrised serial parity generator/checker: accepts a serial bit stream one bit per valid/ready handshake, accumulates parity over a word of `WORD_BITS` data bits, and emits a registered parity result. Odd or even parity is selectable per word. In check mode it also consumes a received parity bit and flags a mismatch. It sits on serial links in the design as the configurable successor to the fixed 3-bit odd-parity generator.

## Interface
- `WORD_BITS`, 3: data bits per word, ≥1.
- `CNT_W`, `$clog2(WORD_BITS+1)`: derived bit-counter width. Do not override.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `in_valid`  in  1  `in_bit` is valid this cycle.
- `in_bit`  in  1  serial data bit; also carries the received parity bit in check mode.
- `in_ready`  out  1  unit can accept a bit this cycle.
- `odd_mode`  in  1  1 = odd parity, 0 = even; sampled with the first data bit of each word.
- `check_mode`  in  1  0 = generate, 1 = check; sampled with the first data bit of each word.
- `out_valid`  out  1  one-cycle pulse when a word result is available.
- `out_bit`  out  1  parity bit for the completed word (expected parity in check mode).
- `par_err`  out  1  check mode only: received parity mismatched; always 0 in generate mode.
- `busy`  out  1  a word is in progress (state ≠ IDLE).

## Operation
- Accept condition: `in_valid && in_ready` at a rising edge. With `in_valid` low the unit stalls with no state change; gaps of any length are allowed.
- States:
  - IDLE: count = 0.
  - DATA: counting data bits.
  - PBIT: check mode only; waiting for the received parity bit.
  - EMIT: one cycle; drives the result.
- Transitions:
  - IDLE → DATA on first accept. Latches `odd_mode` and `check_mode`, sets acc = `in_bit`, count = 1.
  - Exception: if `WORD_BITS`=1, the first accept goes directly to PBIT or EMIT.
  - DATA: each accept does acc ^= `in_bit` and count++. On accepting data bit `WORD_BITS`, go to PBIT if check mode, else EMIT.
  - PBIT → EMIT on accept; the bit is latched as rx.
  - EMIT → IDLE unconditionally after 1 cycle.
- Arithmetic:
  - Generate: `out_bit` = acc ^ odd.
  - Check: `out_bit` = acc ^ odd and `par_err` = acc ^ rx ^ odd.
- `in_ready` = 1 in IDLE, DATA and PBIT; 0 in EMIT. It is combinational from state.
- `out_valid` is high only during EMIT.
- `out_bit` and `par_err` are registered. They update on entry to EMIT and hold until the next EMIT.
- Mode inputs are ignored after the first data bit of a word. A mid-word change does not take effect until the next word.

## Timing
- Reset values: state IDLE, count 0, acc 0, `out_valid` 0, `out_bit` 0, `par_err` 0, `busy` 0. `in_ready` is 1 once reset is released.
- Latency: `out_valid` rises in the cycle after the last accepted bit (last data bit in generate mode, parity bit in check mode).
- Throughput with no stalls:
  - Generate: one word per `WORD_BITS`+1 cycles.
  - Check: one word per `WORD_BITS`+2 cycles.
- A bit presented during EMIT is not accepted. The source must hold it until `in_ready` returns.
- Back-to-back words: a first bit presented in the cycle after EMIT is accepted.
- Reset mid-word clears everything immediately. The partial word is discarded and no `out_valid` is produced for it.
- Count never exceeds `WORD_BITS`. An unreachable state encoding recovers to IDLE.

## Structure
- Package `serial_parity_pkg` holds:
  - the state enum typedef (IDLE, DATA, PBIT, EMIT);
  - the mode constants `MODE_EVEN`/`MODE_ODD` and `MODE_GEN`/`MODE_CHK`.
- One sub-module, `parity_acc`: XOR accumulator with load (first bit) and accumulate enables. The FSM, counter and output registers live in the top.

## Test plan
- Generate, odd, `WORD_BITS`=3, bits 1,0,1 → `out_valid` pulses 1 cycle after third accept, `out_bit`=1, `par_err`=0.
- Generate, even, bits 1,1,1 → `out_bit`=1. Then bits 0,1,1 back-to-back → second result `out_bit`=0, arriving 4 cycles after the first.
- Check, odd, data 1,0,0, rx 0 → `out_bit`=0, `par_err`=0. Repeat with rx 1 → `par_err`=1.
- Stalls: 5 idle cycles between bits 1 and 2 give the same result. With `in_valid` held high through EMIT, the bit is accepted only after EMIT and `in_ready` is 0 for exactly that cycle.
- Reset after 2 accepted bits → outputs 0 asynchronously. A following even word 0,0,0 gives `out_bit`=0 (no carry-over).
- Toggle `odd_mode` after the first bit → ignored. Build with `WORD_BITS`=1, odd, stream 1,0,1 → `out_bit` 0,1,0, one result every 2 cycles.
